// File: rtl/eclk_bus_sync.sv
// eclk_bus_sync: runs 6800-style E-clock bus cycles to the CIAs from a one-hot eclk phase vector
module eclk_bus_sync #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int VMA_PHASE = 3,
  parameter int WDOG_CYC  = 64
) (
  input  logic              clk_28,
  input  logic              reset,
  input  logic [9:0]        eclk,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] cia_rdata,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              e_out,
  output logic              vma,
  output logic              cia_sel,
  output logic              cia_we,
  output logic [ADDR_W-1:0] cia_addr,
  output logic [DATA_W-1:0] cia_wdata
);
  localparam int WW = $clog2(WDOG_CYC + 1);
  typedef enum logic [2:0] {IDLE, ARM, VMA, EHI, DONE} state_t;
  state_t state_q, state_d;
  logic [9:0] eclk_q, ps;
  logic e_q, busy_q, busy_d, vma_q, vma_d, sel_q, sel_d, cwe_q, cwe_d;
  logic we_q, we_d, ack_q, ack_d, err_q, err_d, pulsed_q, tmo;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [WW-1:0] wd_q, wd_d;
  assign ps = eclk & ~eclk_q;
  // wd_q counts cycles since the last phase start; a phase start in the limit cycle wins
  assign tmo = (wd_q == WW'(WDOG_CYC - 1)) && !(|ps) && (state_q inside {ARM, VMA, EHI});
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    vma_d   = vma_q;
    sel_d   = sel_q;
    cwe_d   = cwe_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    wd_d    = |ps ? WW'(1) : wd_q + WW'(1);
    case (state_q)
      IDLE: if (req && !pulsed_q) begin
        we_d    = we;
        addr_d  = addr;
        wdata_d = wdata;
        busy_d  = 1'b1;
        wd_d    = WW'(1);
        state_d = ARM;
      end
      ARM: if (ps[VMA_PHASE]) begin
        vma_d   = 1'b1;
        state_d = VMA;
      end
      VMA: if (ps[6]) begin
        sel_d   = 1'b1;
        cwe_d   = we_q;
        state_d = EHI;
      end
      EHI: if (ps[0]) begin
        rdata_d = we_q ? rdata_q : cia_rdata;
        vma_d   = 1'b0;
        sel_d   = 1'b0;
        cwe_d   = 1'b0;
        ack_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      vma_d   = 1'b0;
      sel_d   = 1'b0;
      cwe_d   = 1'b0;
      err_d   = 1'b1;
      state_d = DONE;
    end
  end
  always_ff @(posedge clk_28) begin
    if (reset) begin
      state_q  <= IDLE;
      eclk_q   <= '0;
      e_q      <= 1'b0;
      busy_q   <= 1'b0;
      vma_q    <= 1'b0;
      sel_q    <= 1'b0;
      cwe_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      pulsed_q <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      eclk_q   <= eclk;
      e_q      <= |eclk[9:6];
      busy_q   <= busy_d;
      vma_q    <= vma_d;
      sel_q    <= sel_d;
      cwe_q    <= cwe_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      pulsed_q <= ack_q | err_q;
      wd_q     <= wd_d;
    end
  end
  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign e_out     = e_q;
  assign vma       = vma_q;
  assign cia_sel   = sel_q;
  assign cia_we    = cwe_q;
  assign cia_addr  = addr_q;
  assign cia_wdata = wdata_q;
endmodule

// File: tb/tb_eclk_bus_sync.sv
// tb_eclk_bus_sync: directed accesses with a queued scoreboard checked by a negedge monitor
module tb_eclk_bus_sync;
  logic clk_28 = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0;
  logic [9:0] eclk = 10'd1;
  logic [3:0] addr = '0, cia_addr;
  logic [7:0] wdata = '0, cia_rdata = '0, rdata, cia_wdata;
  logic ack, err, busy, e_out, vma, cia_sel, cia_we;

  eclk_bus_sync #(.DATA_W(8), .ADDR_W(4), .VMA_PHASE(3), .WDOG_CYC(64)) dut (
    .clk_28(clk_28), .reset(reset), .eclk(eclk), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .cia_rdata(cia_rdata), .ack(ack), .err(err), .rdata(rdata),
    .busy(busy), .e_out(e_out), .vma(vma), .cia_sel(cia_sel), .cia_we(cia_we),
    .cia_addr(cia_addr), .cia_wdata(cia_wdata));

  always #5 clk_28 = ~clk_28;

  typedef struct {bit is_err; bit w; logic [3:0] a; logic [7:0] d; logic [7:0] r;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0, failures = 0, cyc = 0, ph = 0, sub = 0;
  int vma_run = 0, sel_run = 0, we_run = 0;
  bit freeze = 0, zero_e = 0, pend_idle = 0, exp_e = 0, rst_edge = 1;
  logic [7:0] last_rd = '0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(posedge clk_28) cyc <= cyc + 1;

  // nominal E generator: one phase per 4 cycles, with freeze and force-to-zero hooks
  initial forever begin
    @(posedge clk_28);
    #1;
    if (!freeze) begin
      if (sub == 3) begin
        sub = 0;
        ph = (ph == 9) ? 0 : ph + 1;
      end else sub++;
    end
    eclk = zero_e ? 10'd0 : 10'd1 << ph;
  end

  always @(negedge clk_28) begin
    chk("e_out", e_out, rst_edge ? 1'b0 : exp_e);
    exp_e = |eclk[9:6];
    rst_edge = reset;
    if (reset) begin
      vma_run = 0; sel_run = 0; we_run = 0; pend_idle = 0;
    end else begin
      if (pend_idle) begin
        chk("busy_clear", busy, 1'b0);
        pend_idle = 0;
      end
      if (vma) vma_run++;
      if (cia_sel) sel_run++;
      if (cia_we) we_run++;
      if (ack || err) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_pulse: ack=%0b err=%0b with no access outstanding", ack, err);
        end else begin
          mon_e = sbq.pop_front();
          chk("pulse_kind", {ack, err}, mon_e.is_err ? 2'b01 : 2'b10);
          chk("rdata", rdata, mon_e.r);
          chk("busy_at_pulse", busy, 1'b1);
          if (mon_e.is_err) chk("bus_idle_at_err", {vma, cia_sel, cia_we}, 3'b000);
          else begin
            chk("vma_len", vma_run, 28);
            chk("sel_len", sel_run, 16);
            chk("we_len", we_run, mon_e.w ? 16 : 0);
            chk("cia_addr", cia_addr, mon_e.a);
            chk("cia_wdata", cia_wdata, mon_e.d);
          end
        end
        pend_idle = 1; vma_run = 0; sel_run = 0; we_run = 0;
      end
    end
  end

  task automatic wait_ph(input int p, input int s);
    do begin @(posedge clk_28); #2; end while (!(ph == p && sub == s));
  endtask

  task automatic wait_pulse(output int c);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk_28);
      got = ack | err;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL access_timeout: no ack or err within 300 cycles");
    end
    c = cyc;
  endtask

  task automatic do_access(input bit w, input logic [3:0] a, input logic [7:0] d,
                           input logic [7:0] r, input bit is_err, output int lat, output int dc);
    exp_t e;
    int start;
    we = w; addr = a; wdata = d; cia_rdata = r;
    e.is_err = is_err; e.w = w; e.a = a; e.d = d;
    e.r = (w || is_err) ? last_rd : r;
    if (!w && !is_err) last_rd = r;
    sbq.push_back(e);
    req = 1'b1;
    start = cyc;
    wait_pulse(dc);
    lat = dc - start;
    @(posedge clk_28); #2;
    req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, dc, ps_cyc, t1, t2;
    exp_t e;
    repeat (3) @(posedge clk_28);
    #2 reset = 1'b0;
    @(negedge clk_28);
    chk("reset_state", {ack, err, busy, e_out, vma, cia_sel, cia_we, cia_addr, cia_wdata, rdata}, '0);
    // read issued two cycles before ps[3]
    wait_ph(2, 2);
    do_access(1'b0, 4'h1, 8'h00, 8'hA5, 1'b0, lat, dc);
    chk("read_latency", lat, 31);
    // write issued one cycle after ps[3] waits a full period
    wait_ph(3, 1);
    do_access(1'b1, 4'hD, 8'h3C, 8'h77, 1'b0, lat, dc);
    chk("write_latency", lat, 68);
    // back-to-back reads with req held
    wait_ph(5, 0);
    we = 1'b0; addr = 4'h2; wdata = 8'h11; cia_rdata = 8'h5A;
    e.is_err = 0; e.w = 0; e.a = 4'h2; e.d = 8'h11; e.r = 8'h5A;
    sbq.push_back(e);
    e.r = 8'hC3;
    sbq.push_back(e);
    req = 1'b1;
    wait_pulse(t1);
    @(posedge clk_28); #2;
    cia_rdata = 8'hC3;
    wait_pulse(t2);
    chk("b2b_spacing", t2 - t1, 40);
    @(posedge clk_28); #2;
    req = 1'b0;
    last_rd = 8'hC3;
    // reset while E is high with cia_sel asserted
    wait_ph(1, 0);
    we = 1'b0; addr = 4'h6; wdata = 8'h00; cia_rdata = 8'h99; req = 1'b1;
    for (int i = 0; i < 200 && !cia_sel; i++) @(negedge clk_28);
    chk("sel_before_reset", cia_sel, 1'b1);
    @(posedge clk_28); #2;
    reset = 1'b1;
    @(posedge clk_28);
    @(negedge clk_28);
    chk("reset_mid_ehi", {ack, err, busy, e_out, vma, cia_sel, cia_we, cia_addr, cia_wdata, rdata}, '0);
    @(posedge clk_28); #2;
    reset = 1'b0; req = 1'b0; last_rd = 8'h00;
    repeat (5) @(posedge clk_28);
    #2;
    do_access(1'b0, 4'h6, 8'h00, 8'h99, 1'b0, lat, dc);
    // eclk frozen on bit 6 after ps[6]: watchdog abort
    wait_ph(1, 0);
    fork
      do_access(1'b0, 4'h9, 8'h00, 8'hEE, 1'b1, lat, dc);
      begin
        wait_ph(6, 0);
        freeze = 1'b1;
        ps_cyc = cyc;
      end
    join
    chk("wdog_latency", dc - ps_cyc, 64);
    freeze = 1'b0;
    // eclk forced to zero for three cycles during ARM
    wait_ph(1, 2);
    fork
      do_access(1'b0, 4'h3, 8'h00, 8'h3E, 1'b0, lat, dc);
      begin
        wait_ph(1, 3);
        zero_e = 1'b1;
        repeat (3) begin @(posedge clk_28); #2; end
        zero_e = 1'b0;
      end
    join
    chk("zero_gap_latency", lat, 35);
    repeat (10) @(posedge clk_28);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eclk_bus_sync.md
Name: eclk_bus_sync

Overview:
- Consumer of the 10-bit one-hot E-clock phase vector produced by the Amiga clock generator.
- Runs 6800-style synchronous bus cycles to the CIA peripherals on behalf of a fast requester (CPU glue), using a req/ack handshake.
- Derives E, VMA and chip select from the phase vector, aligns each access to an E period, latches read data at the E falling edge and acknowledges.

Parameters:
- DATA_W, 8, CIA data bus width.
- ADDR_W, 4, CIA register address width.
- VMA_PHASE, 3, eclk bit index at whose start VMA asserts; legal range 1..5.
- WDOG_CYC, 64, clk_28 cycles without a phase advance while busy before abort.

Ports:
- clk_28 input 1: 28 MHz clock; sole clock.
- reset input 1: synchronous, active-high reset.
- eclk input 10: one-hot E phase vector; advances one bit per 4 clk_28 cycles; bit0 follows bit9.
- req input 1: access request, level; held high until ack or err.
- we input 1: 1 = write; qualified by req.
- addr input ADDR_W: register address; qualified by req.
- wdata input DATA_W: write data; qualified by req.
- cia_rdata input DATA_W: peripheral read data.
- ack output 1: one-cycle pulse; access complete.
- err output 1: one-cycle pulse; watchdog abort.
- rdata output DATA_W: read data, valid from the ack pulse until the next read ack.
- busy output 1: high from request accept until the ack/err cycle inclusive.
- e_out output 1: registered E; high while eclk[9:6] != 0.
- vma output 1: valid memory address.
- cia_sel output 1: peripheral select; high only while E is high.
- cia_we output 1: peripheral write strobe.
- cia_addr output ADDR_W: latched address.
- cia_wdata output DATA_W: latched write data.

Behaviour:
- All registers and outputs reset to 0 on reset (synchronous). A transaction in flight is dropped with no ack and no err. req must be re-presented after reset.
- Phase start: `ps[i] = eclk[i] & ~eclk_q[i]`, where eclk_q is eclk registered.
  - An all-zero or multi-hot eclk produces no ps for bits that do not newly rise.
  - No decoding error is flagged.
- `e_out <= |eclk[9:6]` every cycle, giving one cycle of latency.
- FSM states: IDLE, ARM, VMA, EHI, DONE.
  - IDLE: when req=1 and ack/err were not pulsed last cycle, latch we/addr/wdata, set busy, go to ARM.
  - ARM: wait for ps[VMA_PHASE]. On it, assert vma and go to VMA. A request accepted after the VMA phase start waits for the next period; no partial cycles.
  - VMA: on ps[6], assert cia_sel, and cia_we if we=1, then go to EHI.
  - EHI: on ps[0] (E fall):
    - capture cia_rdata into rdata if read; rdata is unchanged on writes;
    - drop vma, cia_sel and cia_we;
    - pulse ack;
    - go to DONE.
  - DONE: one cycle; clear busy; go to IDLE. The next req is accepted no earlier than the cycle after DONE.
- cia_addr and cia_wdata hold their latched values from ARM through DONE and keep them in IDLE.
- Watchdog: in ARM, VMA or EHI, count clk_28 cycles since the last phase start (any ps bit); reset the count on each ps.
  - When the count reaches WDOG_CYC: drop vma, cia_sel and cia_we; pulse err; go to DONE.
  - rdata is unchanged on err.
- Latency (nominal eclk, VMA_PHASE=3), req to ack:
  - minimum 7 phases = 28 cycles (+1 accept, ±1 sampling);
  - maximum 17 phases = 68 cycles (+2).
- cia_sel is high for exactly 16 clk_28 cycles per access (phases 6–9).
- vma is high from ps[3] to ps[0]: 28 cycles.
- Simultaneous events:
  - req dropping mid-access does not abort; the cycle completes and ack still pulses.
  - ps and the watchdog limit in the same cycle: ps wins.

Test Plan:
1. Reset mid-EHI with cia_sel=1 -> the next cycle all outputs are 0, no ack; a fresh read afterwards completes normally.
2. Read, req raised 2 cycles before ps[3], cia_rdata=8'hA5 -> vma rises at ps[3]; cia_sel is high for 16 cycles; ack and rdata=A5 at ps[0]; req-to-ack ≈ 30 cycles.
3. Write, addr=4'hD, wdata=8'h3C, req raised 1 cycle after ps[3] -> vma waits for the next period's ps[3]; cia_we and cia_sel are coincident for 16 cycles; cia_addr=D and cia_wdata=3C are stable; ack ≈ 68 cycles after req.
4. Back-to-back reads with req held continuously -> the second access starts after DONE and aligns to the following ps[3]; exactly one ack per access; vma never high across two periods without a low gap.
5. eclk frozen at 10'b0001000000 during VMA with WDOG_CYC=64 -> err pulses exactly 64 cycles after the last ps; vma and cia_sel are 0; no ack; busy clears one cycle later.
6. eclk forced to 0 for 3 cycles during ARM, then resumed one-hot -> no spurious ps; the access completes on the next valid ps[3]; no err.
